// File: rtl/weight_loader.sv
// Weight loader: buffers one N-word image from the host, then bursts it into the weight RAM.
// Optional checksum output of the burst is enabled by defining WEIGHT_LOADER_CSUM_EN.
module weight_loader #(
   parameter int DATA_WIDTH = -1,
   parameter int N          = -1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   input  logic                  load_req,
   input  logic                  start_run,
   input  logic                  stop_run,
   output logic                  load,
   output logic [DATA_WIDTH-1:0] out_weight,
   output logic                  enable_weights,
   output logic                  loaded,
   output logic                  busy
`ifdef WEIGHT_LOADER_CSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] csum
`endif
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int DEPTH = (N > 1) ? N : 2;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, FILL, BURST, LOADED, RUN} state_t;

   state_t                state;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_nxt;
   logic [DATA_WIDTH-1:0] buffer [DEPTH];
   logic                  take;

   assign s_ready = (state == FILL);
   assign take    = s_valid && s_ready;
   assign idx_nxt = idx + IDX_W'(1);
   assign loaded  = (state == LOADED) || (state == RUN);
   assign busy    = (state == FILL) || (state == BURST);

   // Image buffer holds data only; it survives reset.
   always_ff @(posedge clk) begin
      if (take) buffer[idx] <= s_data;
   end

   // The RAM rewinds whenever load and enable_weights are both low, so the burst
   // must be gap-free: word 0 is launched on the final handshake edge itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= '0;
         load           <= 1'b0;
         out_weight     <= '0;
         enable_weights <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_req) begin
                  state <= FILL;
                  idx   <= '0;
               end
            end
            FILL: begin
               if (take) begin
                  if (idx == LAST) begin
                     state      <= BURST;
                     idx        <= '0;
                     load       <= 1'b1;
                     out_weight <= buffer[0];
                  end else begin
                     idx <= idx_nxt;
                  end
               end
            end
            BURST: begin
               if (idx == LAST) begin
                  state <= LOADED;
                  idx   <= '0;
                  load  <= 1'b0;
               end else begin
                  idx        <= idx_nxt;
                  out_weight <= buffer[idx_nxt];
               end
            end
            LOADED: begin
               if (load_req) begin
                  state          <= FILL;
                  idx            <= '0;
                  enable_weights <= 1'b0;
               end else if (start_run) begin
                  state          <= RUN;
                  enable_weights <= 1'b1;
               end
            end
            RUN: begin
               if (load_req) begin
                  state          <= FILL;
                  idx            <= '0;
                  enable_weights <= 1'b0;
               end else if (stop_run) begin
                  state          <= LOADED;
                  enable_weights <= 1'b0;
               end
            end
            default: begin
               state          <= IDLE;
               idx            <= '0;
               load           <= 1'b0;
               enable_weights <= 1'b0;
            end
         endcase
      end
   end

`ifdef WEIGHT_LOADER_CSUM_EN
   // Cleared on the edge that enters BURST, then sums every word presented with load high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (take && (idx == LAST)) begin
         csum <= '0;
      end else if (load) begin
         csum <= csum + out_weight;
      end
   end
`endif

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default -1 (override mandatory), the weight word width.
REQ-002 SHALL have parameter N, default -1 (override mandatory, N>=2), the number of weights per RAM image.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1, meaning a host weight word is offered.
REQ-006 SHALL have port s_data, input, DATA_WIDTH, the host weight word.
REQ-007 SHALL have port s_ready, output, 1, meaning the loader accepts s_data this cycle.
REQ-008 SHALL have port load_req, input, 1, a pulse that starts a new image fill.
REQ-009 SHALL have ports start_run and stop_run, input, 1 each, the run control pulses.
REQ-010 SHALL have port load, output, 1, the RAM write strobe.
REQ-011 SHALL have port out_weight, output, DATA_WIDTH, the RAM write data.
REQ-012 SHALL have port enable_weights, output, 1, the RAM streaming enable.
REQ-013 SHALL have ports loaded and busy, output, 1 each: image resident in RAM; fill or burst in progress.

Function
REQ-014 SHALL implement states IDLE, FILL, BURST, LOADED, RUN.
REQ-015 SHALL keep an internal buffer of N words of DATA_WIDTH and a word index of $clog2(N) bits.
REQ-016 SHALL drive s_ready combinationally high only in FILL.
REQ-017 SHALL, in FILL, write s_data to buffer[index] on each s_valid&&s_ready cycle and increment index; host gaps are allowed.
REQ-018 SHALL move FILL->BURST on the handshake at index N-1, with index reset to 0.
REQ-019 SHALL, in BURST, assert load and present buffer[index] on out_weight (both registered) for exactly N consecutive cycles, with no gap, because the RAM rewinds its address whenever load and enable_weights are both low.
REQ-020 SHALL move BURST->LOADED after the Nth load cycle, so load is low on the following cycle.
REQ-021 SHALL set loaded=1 in LOADED and RUN and loaded=0 in all other states; busy=1 in FILL and BURST only.
REQ-022 SHALL move LOADED->RUN on start_run; enable_weights SHALL be registered high from the next cycle and held throughout RUN.
REQ-023 SHALL move RUN->LOADED on stop_run, with enable_weights low on the next cycle, so the RAM rewinds and the image can be re-run.
REQ-024 SHALL move from IDLE, LOADED or RUN to FILL on load_req, with index cleared and enable_weights deasserted.
REQ-025 SHALL give load_req priority over start_run and stop_run when they coincide; start_run together with stop_run in RUN SHALL act as stop.
REQ-026 SHALL ignore load_req, start_run and stop_run during FILL and BURST, and ignore start_run in IDLE.
REQ-027 SHALL never assert load and enable_weights in the same cycle.

Reset
REQ-028 SHALL, on rst_n low, asynchronously enter IDLE with index=0, load=0, out_weight=0, enable_weights=0, loaded=0, busy=0, s_ready=0.
REQ-029 SHALL not clear buffer contents on reset.
REQ-030 SHALL, on reset during BURST, truncate the burst (load low immediately) and require a new load_req.

Configuration
REQ-031 SHALL support macro WEIGHT_LOADER_CSUM_EN; when it is defined, the module SHALL have an extra output csum, DATA_WIDTH wide.
REQ-032 With WEIGHT_LOADER_CSUM_EN defined, csum SHALL be cleared on entry to BURST, SHALL accumulate the modulo-2^DATA_WIDTH sum of each word driven with load=1, SHALL hold its value in LOADED and RUN, and SHALL reset to 0.
REQ-033 Without WEIGHT_LOADER_CSUM_EN, the csum port and adder SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 DATA_WIDTH=8, N=4, load_req, host words 1,2,3,4 gap-free -> load high for 4 consecutive cycles with out_weight 1,2,3,4, then loaded=1.
REQ-035 The same words with 3-cycle host gaps between them -> burst still 4 contiguous cycles, identical data.
REQ-036 LOADED, start_run -> enable_weights=1 next cycle; stop_run after 10 cycles -> enable_weights=0 next cycle, loaded stays 1; start_run again -> enable_weights=1.
REQ-037 RUN, load_req and stop_run in the same cycle -> FILL, enable_weights=0, s_ready=1, loaded=0.
REQ-038 rst_n pulled low on the 2nd burst cycle -> load=0 asynchronously, IDLE; a later start_run is ignored.
REQ-039 With WEIGHT_LOADER_CSUM_EN, words 0xFF,0x02,0x10,0x01 -> csum=0x12 in LOADED.
